// File: rtl/fight_pkg.sv
// Shared fight definitions: player state encodings, frame data, geometry.
package fight_pkg;

    typedef enum logic [3:0] {
        ST_NORMAL    = 4'd0,
        ST_MOVE_FWD  = 4'd1,
        ST_MOVE_BWD  = 4'd2,
        ST_JUMP      = 4'd3,
        ST_ATK_START = 4'd4,
        ST_ATK_ACT   = 4'd5,
        ST_ATK_REC   = 4'd6,
        ST_DIR_START = 4'd7,
        ST_HITSTUN   = 4'd8,
        ST_BLOCKSTUN = 4'd9,
        ST_KO        = 4'd10
    } player_state_e;

    localparam int unsigned POS_W    = 10;
    localparam int unsigned GAP_W    = 11;
    localparam int unsigned STUN_W   = 5;
    localparam int unsigned HEALTH_W = 3;

    localparam int unsigned SPRITE_W     = 64;
    localparam int unsigned REACH_NORMAL = 32;
    localparam int unsigned REACH_DIR    = 48;

    localparam int unsigned HITSTUN_NORMAL   = 12;
    localparam int unsigned HITSTUN_DIR      = 16;
    localparam int unsigned BLOCKSTUN_NORMAL = 8;
    localparam int unsigned BLOCKSTUN_DIR    = 10;

    localparam int unsigned MAX_HEALTH = 3;
    localparam int unsigned DAMAGE     = 1;

endpackage

// File: rtl/hit_resolver_stun_timer.sv
// Loadable stun frame down-counter; expire marks the last stun tick.
module stun_timer
    import fight_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [STUN_W-1:0] load_val_i,
    input  logic              en_i,
    output logic [STUN_W-1:0] value_o,
    output logic              expire_o
);

    logic [STUN_W-1:0] value_q;
    logic [STUN_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i && value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign expire_o = (value_q == STUN_W'(1));

endmodule

// File: rtl/hit_resolver.sv
// Defender hit/block/whiff resolution, stun states and health.
// Optional: define CHIP_DAMAGE_EN for chip damage on blocked directionals.
module hit_resolver
    import fight_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                opp_attack_active,
    input  logic                opp_dir_attack,
    input  logic [POS_W-1:0]    opp_x,
    input  logic [POS_W-1:0]    self_x,
    input  logic                block_req,
    output logic [3:0]          state,
    output logic                stun,
    output logic [STUN_W-1:0]   stun_frames,
    output logic [HEALTH_W-1:0] health,
    output logic                hit_pulse,
    output logic                block_pulse,
    output logic                ko
);

    player_state_e       state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic                armed_q, armed_d;
    logic                hit_q, hit_d;
    logic                blk_q, blk_d;

    logic [GAP_W-1:0]    front, opp_ext, gap, reach;
    logic                in_range, contact, blocked, in_stun;
    logic [HEALTH_W-1:0] hit_health;

    logic                tmr_load, tmr_en, tmr_expire;
    logic [STUN_W-1:0]   tmr_val;

    assign front   = {1'b0, self_x} + GAP_W'(SPRITE_W);
    assign opp_ext = {1'b0, opp_x};
    assign gap     = (opp_ext < front) ? '0 : opp_ext - front;
    assign reach   = opp_dir_attack ? GAP_W'(REACH_DIR)
                                    : GAP_W'(REACH_NORMAL);
    assign in_range = (gap <= reach);

    assign in_stun = (state_q == ST_HITSTUN) || (state_q == ST_BLOCKSTUN);
    assign contact = opp_attack_active && armed_q && in_range
                     && (state_q != ST_KO);
    assign blocked = block_req && (state_q != ST_HITSTUN);

    assign hit_health = (health_q > HEALTH_W'(DAMAGE))
                      ? health_q - HEALTH_W'(DAMAGE) : '0;

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        armed_d  = opp_attack_active ? armed_q : 1'b1;
        hit_d    = 1'b0;
        blk_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        if (state_q == ST_KO) begin
            state_d = ST_KO;
        end else if (contact) begin
            armed_d = 1'b0;
            if (!blocked) begin
                health_d = hit_health;
                hit_d    = 1'b1;
                tmr_load = 1'b1;
                if (hit_health == '0) begin
                    state_d = ST_KO;
                end else begin
                    state_d = ST_HITSTUN;
                    tmr_val = opp_dir_attack ? STUN_W'(HITSTUN_DIR)
                                             : STUN_W'(HITSTUN_NORMAL);
                end
            end else begin
                state_d  = ST_BLOCKSTUN;
                blk_d    = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = opp_dir_attack ? STUN_W'(BLOCKSTUN_DIR)
                                          : STUN_W'(BLOCKSTUN_NORMAL);
`ifdef CHIP_DAMAGE_EN
                // Chip damage floors at 1 so a block can never KO.
                if (opp_dir_attack && health_q > HEALTH_W'(1)) begin
                    health_d = health_q - HEALTH_W'(1);
                end
`endif
            end
        end else if (in_stun) begin
            tmr_en = 1'b1;
            if (tmr_expire) begin
                state_d = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            health_q <= HEALTH_W'(MAX_HEALTH);
            armed_q  <= 1'b1;
            hit_q    <= 1'b0;
            blk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            armed_q  <= armed_d;
            hit_q    <= hit_d;
            blk_q    <= blk_d;
        end
    end

    stun_timer u_stun_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .value_o    (stun_frames),
        .expire_o   (tmr_expire)
    );

    assign state       = state_q;
    assign stun        = in_stun;
    assign health      = health_q;
    assign hit_pulse   = hit_q;
    assign block_pulse = blk_q;
    assign ko          = (state_q == ST_KO);

endmodule
